// File: rtl/bp_update_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler_pkg
// Shared types for the branch-predictor update path:
//   prediction_choice  - predicted/actual branch direction (not_take=0, take=1)
//   bp_update_t        - one queued predictor update {pc, taken}
//   bp_sched_state_t   - scheduler FSM states
//   BP_UPD_DEPTH       - default update FIFO depth
// -----------------------------------------------------------------------------
package bp_update_scheduler_pkg;

    typedef enum logic {
        not_take = 1'b0,
        take     = 1'b1
    } prediction_choice;

    typedef struct packed {
        logic [31:0]      pc;
        prediction_choice taken;
    } bp_update_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } bp_sched_state_t;

    localparam int BP_UPD_DEPTH = 4;

endpackage

// File: rtl/bp_update_fifo.sv
// -----------------------------------------------------------------------------
// bp_update_fifo
// Synchronous FIFO of bp_update_t entries.
// Ports:
//   clk, rst_n       clock / async active-low reset (pointers and count only)
//   push_i, wdata_i  enqueue request and data (ignored when full)
//   pop_i            dequeue head (ignored when empty)
//   rdata_o          current head entry
//   full_o, empty_o  occupancy flags
//   count_o          current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module bp_update_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  bp_update_t             wdata_i,
    output bp_update_t             rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

    bp_update_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage carries no reset: stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler
// Buffers resolved branches and drains them one per cycle into the global
// branch predictor's single update port; counts branches and mispredicts.
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   res_valid/res_ready               resolved-branch handshake
//   res_pc, res_taken, res_predicted  resolved branch payload
//   bp_block                          stall predictor updates
//   stat_clear                        synchronous clear of statistics
//   bp_write_en/bp_prev_pc/bp_branch_taken  registered predictor update port
//   mispredict                        registered pulse per accepted mispredict
//   branch_count, mispredict_count    saturating statistics
//   pending                           FIFO occupancy
// -----------------------------------------------------------------------------
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [31:0]            res_pc,
    input  prediction_choice       res_taken,
    input  prediction_choice       res_predicted,
    input  logic                   bp_block,
    input  logic                   stat_clear,
    output logic                   bp_write_en,
    output logic [31:0]            bp_prev_pc,
    output prediction_choice       bp_branch_taken,
    output logic                   mispredict,
    output logic [CNT_W-1:0]       branch_count,
    output logic [CNT_W-1:0]       mispredict_count,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int CW = $clog2(DEPTH) + 1;

    bp_sched_state_t  state_q, state_d;
    bp_update_t       wr_entry, head;
    logic             full, empty, accept, drain, mis_now;
    logic [CW-1:0]    pending_nxt;
    logic             write_en_q;
    logic [31:0]      prev_pc_q;
    prediction_choice taken_q;
    logic             mispredict_q;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mis_cnt_q, mis_cnt_d;

    assign res_ready = !full;
    assign accept    = res_valid && res_ready;
    assign drain     = !empty && !bp_block && (state_q != IDLE);
    assign mis_now   = (res_taken != res_predicted);
    assign wr_entry  = '{pc: res_pc, taken: res_taken};

    bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .pop_i   (drain),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (pending)
    );

    // Occupancy after this cycle's accept/drain; drives the FSM.
    always_comb begin
        pending_nxt = pending;
        if (accept && !drain)      pending_nxt = pending + 1'b1;
        else if (!accept && drain) pending_nxt = pending - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (pending_nxt != '0) state_d = DRAIN;
            DRAIN, HOLD: begin
                if (pending_nxt == '0) state_d = IDLE;
                else if (bp_block)     state_d = HOLD;
                else                   state_d = DRAIN;
            end
            default:     state_d = IDLE;
        endcase
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        if (stat_clear) begin
            branch_cnt_d = '0;
            mis_cnt_d    = '0;
        end else if (accept) begin
            if (branch_cnt_q != '1)          branch_cnt_d = branch_cnt_q + 1'b1;
            if (mis_now && (mis_cnt_q != '1)) mis_cnt_d   = mis_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_en_q   <= 1'b0;
            prev_pc_q    <= '0;
            taken_q      <= not_take;
            mispredict_q <= 1'b0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            write_en_q   <= drain;
            mispredict_q <= accept && mis_now;
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
            // Update port holds its last payload between strobes.
            if (drain) begin
                prev_pc_q <= head.pc;
                taken_q   <= head.taken;
            end
        end
    end

    assign bp_write_en      = write_en_q;
    assign bp_prev_pc       = prev_pc_q;
    assign bp_branch_taken  = taken_q;
    assign mispredict       = mispredict_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mis_cnt_q;

endmodule
